cp0_regfile: RTL and testbench

// CP0 state holder driven by the M-stage exception unit: consumes its exception

---
 rtl/cp0_regfile.sv | 156 +++++++++++++++
 tb/tb_cp0_regfile.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// CP0 register file: commits exception/ERET state from the M stage, serves MTC0/MFC0,
// runs the Count/Compare timer and supplies the redirect PC.
module cp0_regfile #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
   parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
   parameter int          COUNT_DIV    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [4:0]  raddr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   input  logic [5:0]  int_i,
   input  logic [4:0]  exception_code_i,
   input  logic        eret_i,
   input  logic [31:0] pc_i,
   input  logic        in_delayslot_i,
   input  logic [31:0] bad_addr_i,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic        timer_int_o,
   output logic [31:0] redirect_pc_o
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   localparam int                 PHASE_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(COUNT_DIV - 1);

   logic [31:0]        badvaddr;
   logic [31:0]        count;
   logic [31:0]        compare;
   logic [31:0]        epc;
   logic [PHASE_W-1:0] phase;
   logic [7:0]         im;
   logic               exl;
   logic               ie;
   logic               bd;
   logic               ti;
   logic [5:0]         ip_hw;
   logic [1:0]         ip_sw;
   logic [4:0]         exc_code;

   logic exc_taken;
   logic addr_fault;
   logic count_tick;
   logic wr_count;
   logic wr_compare;
   logic wr_status;
   logic wr_cause;
   logic wr_epc;

   // Codes with bit 4 set mean "no exception"; code 0 (interrupt) is a real one.
   assign exc_taken  = ~exception_code_i[4];
   assign addr_fault = (exception_code_i == 5'd4) || (exception_code_i == 5'd5);
   assign count_tick = (phase == PHASE_LAST);

   assign wr_count   = we_i && (waddr_i == REG_COUNT);
   assign wr_compare = we_i && (waddr_i == REG_COMPARE);
   assign wr_status  = we_i && (waddr_i == REG_STATUS);
   assign wr_cause   = we_i && (waddr_i == REG_CAUSE);
   assign wr_epc     = we_i && (waddr_i == REG_EPC);

   // NOTE: state registers use non-blocking assignments so every block samples
   // the pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         im  <= STATUS_RESET[15:8];
         exl <= STATUS_RESET[1];
         ie  <= STATUS_RESET[0];
      end else begin
         if (wr_status) begin
            im <= data_i[15:8];
            ie <= data_i[0];
         end
         if (exc_taken)      exl <= 1'b1;
         else if (eret_i)    exl <= 1'b0;
         else if (wr_status) exl <= data_i[1];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bd       <= 1'b0;
         ti       <= 1'b0;
         ip_hw    <= '0;
         ip_sw    <= '0;
         exc_code <= '0;
      end else begin
         if (exc_taken && !exl) bd <= in_delayslot_i;
         if (exc_taken)         exc_code <= exception_code_i;
         if (wr_cause)          ip_sw <= data_i[9:8];
         ip_hw <= {int_i[5] | ti, int_i[4:0]};
         // A Compare write acknowledges the timer even if a match lands this cycle.
         if (wr_compare)            ti <= 1'b0;
         else if (count == compare) ti <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         epc      <= '0;
         badvaddr <= '0;
      end else begin
         // While EXL is set a nested exception keeps the original return address.
         if (exc_taken) begin
            if (!exl) epc <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
         end else if (wr_epc) begin
            epc <= data_i;
         end
         if (addr_fault) badvaddr <= bad_addr_i;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         phase   <= '0;
         count   <= '0;
         compare <= '0;
      end else begin
         phase <= count_tick ? '0 : phase + 1'b1;
         if (wr_count)        count <= data_i;
         else if (count_tick) count <= count + 32'd1;
         if (wr_compare) compare <= data_i;
      end
   end

   assign status_o      = {STATUS_RESET[31:16], im, STATUS_RESET[7:2], exl, ie};
   assign cause_o       = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exc_code, 2'b00};
   assign epc_o         = epc;
   assign timer_int_o   = ti;
   assign redirect_pc_o = exc_taken ? EXC_VECTOR : epc;

   // NOTE: the default assignment first keeps this combinational block latch-free.
   always_comb begin
      data_o = '0;
      case (raddr_i)
         REG_BADVADDR: data_o = badvaddr;
         REG_COUNT:    data_o = count;
         REG_COMPARE:  data_o = compare;
         REG_STATUS:   data_o = status_o;
         REG_CAUSE:    data_o = cause_o;
         REG_EPC:      data_o = epc;
         default:      data_o = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus randomized traffic
// checked against a word-level register model.
module tb_cp0_regfile;

   localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
   localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
   localparam int          COUNT_DIV    = 2;
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

   logic        clk = 1'b0;
   logic        resetn;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [4:0]  raddr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic [5:0]  int_i;
   logic [4:0]  exception_code_i;
   logic        eret_i;
   logic [31:0] pc_i;
   logic        in_delayslot_i;
   logic [31:0] bad_addr_i;
   logic [31:0] status_o;
   logic [31:0] cause_o;
   logic [31:0] epc_o;
   logic        timer_int_o;
   logic [31:0] redirect_pc_o;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: whole architectural register words.
   logic [31:0] m_status, m_cause, m_epc, m_count, m_compare, m_badv;
   int          m_cycles;

   cp0_regfile #(
      .EXC_VECTOR  (EXC_VECTOR),
      .STATUS_RESET(STATUS_RESET),
      .COUNT_DIV   (COUNT_DIV)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .we_i            (we_i),
      .waddr_i         (waddr_i),
      .raddr_i         (raddr_i),
      .data_i          (data_i),
      .data_o          (data_o),
      .int_i           (int_i),
      .exception_code_i(exception_code_i),
      .eret_i          (eret_i),
      .pc_i            (pc_i),
      .in_delayslot_i  (in_delayslot_i),
      .bad_addr_i      (bad_addr_i),
      .status_o        (status_o),
      .cause_o         (cause_o),
      .epc_o           (epc_o),
      .timer_int_o     (timer_int_o),
      .redirect_pc_o   (redirect_pc_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic model_reset();
      m_status  = STATUS_RESET;
      m_cause   = '0;
      m_epc     = '0;
      m_count   = '0;
      m_compare = '0;
      m_badv    = '0;
      m_cycles  = 0;
   endtask

   // One clock edge of the architectural rules, lowest priority applied first.
   task automatic model_step();
      logic        exc;
      logic [31:0] n_status, n_cause, n_epc, n_count, n_compare, n_badv;
      exc       = (exception_code_i < 5'd16);
      n_status  = m_status;
      n_cause   = m_cause;
      n_epc     = m_epc;
      n_count   = m_count;
      n_compare = m_compare;
      n_badv    = m_badv;
      n_cause[15:10] = {int_i[5] | m_cause[30], int_i[4:0]};
      if (m_count == m_compare) n_cause[30] = 1'b1;
      if ((m_cycles % COUNT_DIV) == COUNT_DIV - 1) n_count = m_count + 32'd1;
      if (we_i) begin
         case (waddr_i)
            5'd9:  n_count = data_i;
            5'd11: begin n_compare = data_i; n_cause[30] = 1'b0; end
            5'd12: n_status = (m_status & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
            5'd13: n_cause[9:8] = data_i[9:8];
            5'd14: n_epc = data_i;
            default: ;
         endcase
      end
      if (eret_i && !exc) n_status[1] = 1'b0;
      if (exc) begin
         if (!m_status[1]) begin
            n_epc        = in_delayslot_i ? pc_i - 32'd4 : pc_i;
            n_cause[31]  = in_delayslot_i;
         end else begin
            n_epc = m_epc;
         end
         n_status[1]   = 1'b1;
         n_cause[6:2]  = exception_code_i;
         if (exception_code_i == 5'd4 || exception_code_i == 5'd5) n_badv = bad_addr_i;
      end
      m_status  = n_status;
      m_cause   = n_cause;
      m_epc     = n_epc;
      m_count   = n_count;
      m_compare = n_compare;
      m_badv    = n_badv;
      m_cycles++;
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] addr);
      case (addr)
         5'd8:    return m_badv;
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         default: return 32'h0;
      endcase
   endfunction

   task automatic cycle();
      @(posedge clk);
      if (resetn) model_step();
      #1;
   endtask

   task automatic set_idle();
      we_i             = 1'b0;
      waddr_i          = '0;
      data_i           = '0;
      int_i            = '0;
      exception_code_i = 5'h1F;
      eret_i           = 1'b0;
      pc_i             = '0;
      in_delayslot_i   = 1'b0;
      bad_addr_i       = '0;
   endtask

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] value);
      we_i    = 1'b1;
      waddr_i = addr;
      data_i  = value;
      cycle();
      we_i    = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      set_idle();
      raddr_i = 5'd9;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (status_o !== 32'h0040_0000) $display("FAIL reset_status: got %h want %h", status_o, 32'h0040_0000); else n_pass++;
      n_total++; if (cause_o !== 32'h0) $display("FAIL reset_cause: got %h want 0", cause_o); else n_pass++;
      n_total++; if (epc_o !== 32'h0) $display("FAIL reset_epc: got %h want 0", epc_o); else n_pass++;
      n_total++; if (data_o !== 32'h0) $display("FAIL reset_count: got %h want 0", data_o); else n_pass++;
      n_total++; if (timer_int_o !== 1'b0) $display("FAIL reset_ti: got %b want 0", timer_int_o); else n_pass++;
      resetn = 1'b1;
      #1;
      n_total++; if (redirect_pc_o !== 32'h0) $display("FAIL reset_redirect: got %h want 0", redirect_pc_o); else n_pass++;
      cycle();
      n_total++; if (data_o !== 32'h0) $display("FAIL count_after_1: got %h want 0", data_o); else n_pass++;
      cycle();
      n_total++; if (data_o !== 32'h1) $display("FAIL count_after_2: got %h want 1", data_o); else n_pass++;
   endtask

   task automatic test_timer();
      bit found = 0;
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      raddr_i = 5'd9;
      #1;
      n_total++; if (data_o !== 32'h0) $display("FAIL timer_count_written: got %h want 0", data_o); else n_pass++;
      for (int i = 0; i < 40 && !found; i++) begin
         if (m_count == 32'd5) begin
            found = 1;
            n_total++; if (timer_int_o !== 1'b0) $display("FAIL timer_before_hit: got %b want 0", timer_int_o); else n_pass++;
            cycle();
            n_total++; if (timer_int_o !== 1'b1) $display("FAIL timer_hit: got %b want 1", timer_int_o); else n_pass++;
            n_total++; if (cause_o[30] !== 1'b1) $display("FAIL timer_cause_ti: got %b want 1", cause_o[30]); else n_pass++;
            cycle();
            n_total++; if (cause_o[15] !== 1'b1) $display("FAIL timer_ip7: got %b want 1", cause_o[15]); else n_pass++;
         end else begin
            cycle();
         end
      end
      if (!found) begin
         n_total++;
         $display("FAIL timer_reach_5: got count %h want 5 within 40 cycles", m_count);
      end
      mtc0(5'd11, 32'd100);
      n_total++; if (timer_int_o !== 1'b0) $display("FAIL timer_clear: got %b want 0", timer_int_o); else n_pass++;
      n_total++; if (cause_o[30] !== 1'b0) $display("FAIL timer_clear_cause: got %b want 0", cause_o[30]); else n_pass++;
   endtask

   task automatic test_exception();
      exception_code_i = 5'h04;
      pc_i             = 32'h8000_1004;
      in_delayslot_i   = 1'b1;
      bad_addr_i       = 32'h8000_1001;
      raddr_i          = 5'd8;
      #1;
      n_total++; if (redirect_pc_o !== 32'hBFC0_0380) $display("FAIL exc_redirect: got %h want %h", redirect_pc_o, 32'hBFC0_0380); else n_pass++;
      cycle();
      set_idle();
      #1;
      n_total++; if (epc_o !== 32'h8000_1000) $display("FAIL exc_epc: got %h want %h", epc_o, 32'h8000_1000); else n_pass++;
      n_total++; if (cause_o[31] !== 1'b1) $display("FAIL exc_bd: got %b want 1", cause_o[31]); else n_pass++;
      n_total++; if (status_o[1] !== 1'b1) $display("FAIL exc_exl: got %b want 1", status_o[1]); else n_pass++;
      n_total++; if (cause_o[6:2] !== 5'd4) $display("FAIL exc_code: got %0d want 4", cause_o[6:2]); else n_pass++;
      n_total++; if (data_o !== 32'h8000_1001) $display("FAIL exc_badvaddr: got %h want %h", data_o, 32'h8000_1001); else n_pass++;

      exception_code_i = 5'h0C;
      pc_i             = 32'h1234_5678;
      bad_addr_i       = 32'hDEAD_BEEF;
      cycle();
      set_idle();
      #1;
      n_total++; if (epc_o !== 32'h8000_1000) $display("FAIL nested_epc: got %h want %h", epc_o, 32'h8000_1000); else n_pass++;
      n_total++; if (cause_o[6:2] !== 5'd12) $display("FAIL nested_code: got %0d want 12", cause_o[6:2]); else n_pass++;
      n_total++; if (cause_o[31] !== 1'b1) $display("FAIL nested_bd: got %b want 1", cause_o[31]); else n_pass++;
      n_total++; if (data_o !== 32'h8000_1001) $display("FAIL nested_badvaddr: got %h want %h", data_o, 32'h8000_1001); else n_pass++;

      eret_i = 1'b1;
      #1;
      n_total++; if (redirect_pc_o !== 32'h8000_1000) $display("FAIL eret_redirect: got %h want %h", redirect_pc_o, 32'h8000_1000); else n_pass++;
      cycle();
      set_idle();
      #1;
      n_total++; if (status_o[1] !== 1'b0) $display("FAIL eret_exl: got %b want 0", status_o[1]); else n_pass++;

      eret_i           = 1'b1;
      exception_code_i = 5'h08;
      pc_i             = 32'h0000_2000;
      cycle();
      set_idle();
      #1;
      n_total++; if (status_o[1] !== 1'b1) $display("FAIL eret_vs_exc_exl: got %b want 1", status_o[1]); else n_pass++;
      n_total++; if (cause_o[6:2] !== 5'd8) $display("FAIL eret_vs_exc_code: got %0d want 8", cause_o[6:2]); else n_pass++;
      n_total++; if (epc_o !== 32'h0000_2000) $display("FAIL eret_vs_exc_epc: got %h want %h", epc_o, 32'h0000_2000); else n_pass++;
      n_total++; if (cause_o[31] !== 1'b0) $display("FAIL eret_vs_exc_bd: got %b want 0", cause_o[31]); else n_pass++;
   endtask

   task automatic test_mtc0_conflict();
      we_i             = 1'b1;
      waddr_i          = 5'd12;
      data_i           = 32'hFFFF_FFFF;
      exception_code_i = 5'h00;
      pc_i             = 32'h0000_3000;
      cycle();
      set_idle();
      raddr_i = 5'd7;
      #1;
      n_total++; if (status_o !== 32'h0040_FF03) $display("FAIL mtc0_exc_status: got %h want %h", status_o, 32'h0040_FF03); else n_pass++;
      n_total++; if (cause_o[6:2] !== 5'd0) $display("FAIL mtc0_exc_code: got %0d want 0", cause_o[6:2]); else n_pass++;
      n_total++; if (epc_o !== 32'h0000_2000) $display("FAIL mtc0_exc_epc: got %h want %h", epc_o, 32'h0000_2000); else n_pass++;
      n_total++; if (data_o !== 32'h0) $display("FAIL mfc0_unimpl7: got %h want 0", data_o); else n_pass++;
      raddr_i = 5'd10;
      #1;
      n_total++; if (data_o !== 32'h0) $display("FAIL mfc0_unimpl10: got %h want 0", data_o); else n_pass++;

      mtc0(5'd13, 32'hFFFF_FFFF);
      n_total++; if (cause_o[9:8] !== 2'b11) $display("FAIL mtc0_cause_ip: got %b want 11", cause_o[9:8]); else n_pass++;
      n_total++; if ({cause_o[31], cause_o[6:2]} !== 6'b0) $display("FAIL mtc0_cause_ro: got %b want 0", {cause_o[31], cause_o[6:2]}); else n_pass++;
      mtc0(5'd8, 32'h0);
      raddr_i = 5'd8;
      #1;
      n_total++; if (data_o !== 32'h8000_1001) $display("FAIL badvaddr_ro: got %h want %h", data_o, 32'h8000_1001); else n_pass++;

      we_i    = 1'b1;
      waddr_i = 5'd14;
      data_i  = 32'hA000_0040;
      eret_i  = 1'b1;
      cycle();
      set_idle();
      #1;
      n_total++; if (epc_o !== 32'hA000_0040) $display("FAIL eret_mtc0_epc: got %h want %h", epc_o, 32'hA000_0040); else n_pass++;
      n_total++; if (status_o[1] !== 1'b0) $display("FAIL eret_mtc0_exl: got %b want 0", status_o[1]); else n_pass++;
   endtask

   task automatic test_ip();
      int_i = 6'b010101;
      #1;
      n_total++; if (cause_o[15:10] !== 6'b0) $display("FAIL ip_latency: got %b want 000000", cause_o[15:10]); else n_pass++;
      cycle();
      n_total++; if (cause_o[15:10] !== 6'b010101) $display("FAIL ip_sample1: got %b want 010101", cause_o[15:10]); else n_pass++;
      int_i = 6'b100000;
      cycle();
      n_total++; if (cause_o[15:10] !== 6'b100000) $display("FAIL ip_sample2: got %b want 100000", cause_o[15:10]); else n_pass++;
      set_idle();
   endtask

   task automatic test_count_wrap();
      mtc0(5'd9, 32'hFFFF_FFFF);
      raddr_i = 5'd9;
      #1;
      n_total++; if (data_o !== 32'hFFFF_FFFF) $display("FAIL count_write: got %h want FFFFFFFF", data_o); else n_pass++;
      cycle();
      cycle();
      n_total++; if (data_o !== 32'h0) $display("FAIL count_wrap: got %h want 0", data_o); else n_pass++;
   endtask

   task automatic test_random(input int iterations);
      logic [31:0] exp_redirect;
      for (int i = 0; i < iterations; i++) begin
         we_i             = ($urandom_range(0, 3) == 0);
         waddr_i          = 5'($urandom_range(7, 15));
         data_i           = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
         raddr_i          = 5'($urandom_range(7, 15));
         int_i            = 6'($urandom);
         exception_code_i = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(16, 31));
         eret_i           = ($urandom_range(0, 7) == 0);
         pc_i             = $urandom & 32'hFFFF_FFFC;
         in_delayslot_i   = 1'($urandom_range(0, 1));
         bad_addr_i       = $urandom;
         #1;
         exp_redirect = (exception_code_i < 5'd16) ? EXC_VECTOR : m_epc;
         n_total++; if (status_o !== m_status) $display("FAIL rand_status[%0d]: got %h want %h", i, status_o, m_status); else n_pass++;
         n_total++; if (cause_o !== m_cause) $display("FAIL rand_cause[%0d]: got %h want %h", i, cause_o, m_cause); else n_pass++;
         n_total++; if (epc_o !== m_epc) $display("FAIL rand_epc[%0d]: got %h want %h", i, epc_o, m_epc); else n_pass++;
         n_total++; if (timer_int_o !== m_cause[30]) $display("FAIL rand_ti[%0d]: got %b want %b", i, timer_int_o, m_cause[30]); else n_pass++;
         n_total++; if (redirect_pc_o !== exp_redirect) $display("FAIL rand_redirect[%0d]: got %h want %h", i, redirect_pc_o, exp_redirect); else n_pass++;
         n_total++; if (data_o !== exp_read(raddr_i)) $display("FAIL rand_mfc0[%0d] addr %0d: got %h want %h", i, raddr_i, data_o, exp_read(raddr_i)); else n_pass++;
         cycle();
      end
      set_idle();
   endtask

   task automatic test_reset_mid();
      we_i    = 1'b1;
      waddr_i = 5'd14;
      data_i  = 32'h1357_9BDF;
      int_i   = 6'h3F;
      raddr_i = 5'd9;
      @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      n_total++; if (status_o !== STATUS_RESET) $display("FAIL midreset_status: got %h want %h", status_o, STATUS_RESET); else n_pass++;
      n_total++; if (cause_o !== 32'h0) $display("FAIL midreset_cause: got %h want 0", cause_o); else n_pass++;
      n_total++; if (epc_o !== 32'h0) $display("FAIL midreset_epc: got %h want 0", epc_o); else n_pass++;
      n_total++; if (data_o !== 32'h0) $display("FAIL midreset_count: got %h want 0", data_o); else n_pass++;
      n_total++; if (timer_int_o !== 1'b0) $display("FAIL midreset_ti: got %b want 0", timer_int_o); else n_pass++;
      model_reset();
      set_idle();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      test_random(60);
   endtask

   initial begin
      test_reset();
      test_timer();
      test_exception();
      test_mtc0_conflict();
      test_ip();
      test_count_wrap();
      test_random(400);
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
